// File: rtl/vedic_64_dot_acc.sv
// Dot-product sequencer/accumulator feeding the registered 64x64 Vedic multiplier.
// Build macro VEDIC_DOT_ACC_SAT_EN: accumulator saturates on overflow instead of wrapping.
module vedic_64_dot_acc #(
  parameter int MUL_LAT = 2,
  parameter int ACC_W   = 136,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   dot_len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_a,
  input  logic [63:0]        in_b,
  output logic [63:0]        mul_a,
  output logic [63:0]        mul_b,
  input  logic [127:0]       mul_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [LEN_W-1:0]   retired_q, retired_d;
  logic [MUL_LAT:0]   vld_q, vld_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [63:0]        mul_a_q, mul_a_d;
  logic [63:0]        mul_b_q, mul_b_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               hs;
  logic [ACC_W:0]     sum;

  function automatic logic [ACC_W:0] add_wide(input logic [ACC_W-1:0] acc,
                                              input logic [127:0]     prod);
    return {1'b0, acc} + (ACC_W+1)'(prod);
  endfunction

`ifdef VEDIC_DOT_ACC_SAT_EN
  // MSB of s is the "overflowed at some point in this job" flag.
  function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W:0] s);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    hs        = (state_q == RUN) && in_valid && in_ready_q;
    sum       = add_wide(acc_q, mul_result);
    // Bit 0 marks the operand register stage; bit MUL_LAT marks a stable product.
    vld_d     = {vld_q[MUL_LAT-1:0], hs};

    if (hs) begin
      mul_a_d  = in_a;
      mul_b_d  = in_b;
      issued_d = issued_q + LEN_W'(1);
    end

    if (vld_q[MUL_LAT] && (state_q == RUN || state_q == DRAIN)) begin
`ifdef VEDIC_DOT_ACC_SAT_EN
      acc_d = saturate({sum[ACC_W] | ovf_q, sum[ACC_W-1:0]});
`else
      acc_d = sum[ACC_W-1:0];
`endif
      ovf_d     = ovf_q | sum[ACC_W];
      retired_d = retired_q + LEN_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = dot_len;
          acc_d     = '0;
          issued_d  = '0;
          retired_d = '0;
          ovf_d     = 1'b0;
          vld_d     = '0;
          state_d   = (dot_len == '0) ? DONE : RUN;
        end
      end
      RUN:   if (issued_d == len_q) state_d = DRAIN;
      DRAIN: if (retired_q == len_q && vld_q == '0) state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == RUN) && (issued_d != len_d);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      retired_q   <= '0;
      vld_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      retired_q   <= retired_d;
      vld_q       <= vld_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_vedic_64_dot_acc.sv
// Scoreboard bench for vedic_64_dot_acc: a default (ACC_W=136) and a narrow (ACC_W=128)
// instance run the same directed jobs, each behind a two-stage registered multiplier model.
module tb_vedic_64_dot_acc;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  dot_len = '0;
  logic         in_valid = 1'b0;
  logic [63:0]  in_a = '0;
  logic [63:0]  in_b = '0;
  logic         out_ready = 1'b0;

  logic         busy_0, in_ready_0, out_valid_0, out_ovf_0;
  logic [63:0]  mul_a_0, mul_b_0;
  logic [127:0] mul_result_0, mul_p1_0;
  logic [135:0] out_sum_0;

  logic         busy_1, in_ready_1, out_valid_1, out_ovf_1;
  logic [63:0]  mul_a_1, mul_b_1;
  logic [127:0] mul_result_1, mul_p1_1;
  logic [127:0] out_sum_1;

  int checks = 0;
  int failures = 0;

  logic [136:0] q0[$];
  logic [136:0] q1[$];

  always #5 clk = ~clk;

  vedic_64_dot_acc #(.MUL_LAT(2), .ACC_W(136), .LEN_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .dot_len(dot_len), .busy(busy_0),
    .in_valid(in_valid), .in_ready(in_ready_0), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a_0), .mul_b(mul_b_0), .mul_result(mul_result_0),
    .out_valid(out_valid_0), .out_ready(out_ready), .out_sum(out_sum_0), .out_ovf(out_ovf_0)
  );

  vedic_64_dot_acc #(.MUL_LAT(2), .ACC_W(128), .LEN_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .dot_len(dot_len), .busy(busy_1),
    .in_valid(in_valid), .in_ready(in_ready_1), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a_1), .mul_b(mul_b_1), .mul_result(mul_result_1),
    .out_valid(out_valid_1), .out_ready(out_ready), .out_sum(out_sum_1), .out_ovf(out_ovf_1)
  );

  // Two-stage registered multiplier models (MUL_LAT = 2)
  always @(posedge clk) begin
    mul_p1_0     <= 128'(mul_a_0) * 128'(mul_b_0);
    mul_result_0 <= mul_p1_0;
    mul_p1_1     <= 128'(mul_a_1) * 128'(mul_b_1);
    mul_result_1 <= mul_p1_1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [135:0] s0, input logic o0,
                      input logic [135:0] s1, input logic o1);
    q0.push_back({o0, s0});
    q1.push_back({o1, s1});
  endtask

  task automatic start_job(input logic [15:0] len);
    dot_len = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic feed(input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!(in_ready_0 && in_ready_1) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL feed_timeout: in_ready %b/%b never rose", in_ready_0, in_ready_1);
    end
    tick();
    in_valid = 1'b0;
    chk("mul_a_0", mul_a_0, a);
    chk("mul_b_0", mul_b_0, b);
    chk("mul_a_1", mul_a_1, a);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(out_valid_0 && out_valid_1) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: out_valid %b/%b never rose", out_valid_0, out_valid_1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("busy_after_ack_0", busy_0, 1'b0);
    chk("busy_after_ack_1", busy_1, 1'b0);
    chk("ovld_after_ack_0", out_valid_0, 1'b0);
  endtask

  // Monitor: every presented result must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_0) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result_0: sum %h", out_sum_0);
        end else begin
          chk("out_sum_0", out_sum_0, q0[0][135:0]);
          chk("out_ovf_0", out_ovf_0, q0[0][136]);
          if (out_ready) void'(q0.pop_front());
        end
      end
      if (out_valid_1) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result_1: sum %h", out_sum_1);
        end else begin
          chk("out_sum_1", out_sum_1, q1[0][135:0]);
          chk("out_ovf_1", out_ovf_1, q1[0][136]);
          if (out_ready) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", busy_0, 1'b0);
    chk("rst_in_ready", in_ready_0, 1'b0);
    chk("rst_out_valid", out_valid_0, 1'b0);
    chk("rst_out_sum", out_sum_0, 136'd0);
    chk("rst_mul_a", mul_a_0, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Single term 3*5 with exact latency
    push(136'd15, 1'b0, 136'd15, 1'b0);
    start_job(16'd1);
    chk("t1_busy", busy_0, 1'b1);
    chk("t1_in_ready", in_ready_0, 1'b1);
    in_a = 64'd3;
    in_b = 64'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_mul_a", mul_a_0, 64'd3);
    chk("t1_in_ready_drop", in_ready_0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_ovld_early", out_valid_0, 1'b0);
    end
    tick();
    chk("t1_ovld_e4", out_valid_0, 1'b1);
    chk("t1_ovld_e4_1", out_valid_1, 1'b1);
    wait_done();

    // Back-to-back stream: 1*2 + 3*4 + 5*6 + 7*8 = 100
    push(136'd100, 1'b0, 136'd100, 1'b0);
    start_job(16'd4);
    feed(64'd1, 64'd2);
    feed(64'd3, 64'd4);
    feed(64'd5, 64'd6);
    feed(64'd7, 64'd8);
    chk("t2_in_ready_low", in_ready_0, 1'b0);
    chk("t2_in_ready_low_1", in_ready_1, 1'b0);
    wait_done();

    // Max operands: 2*(2^64-1)^2 = 2^129 - 2^66 + 2; overflows the 128-bit instance
`ifdef VEDIC_DOT_ACC_SAT_EN
    push(136'h1_FFFF_FFFF_FFFF_FFFC_0000_0000_0000_0002, 1'b0,
         136'h00_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1);
`else
    push(136'h1_FFFF_FFFF_FFFF_FFFC_0000_0000_0000_0002, 1'b0,
         136'h00_FFFF_FFFF_FFFF_FFFC_0000_0000_0000_0002, 1'b1);
`endif
    start_job(16'd2);
    feed(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    feed(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done();

    // Zero-length job, backpressure, and a start pulse during DONE
    push(136'd0, 1'b0, 136'd0, 1'b0);
    start_job(16'd0);
    chk("t4_ovld_next", out_valid_0, 1'b1);
    chk("t4_ovld_next_1", out_valid_1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        dot_len = 16'd3;
        start   = 1'b1;
      end
      tick();
      start = 1'b0;
      chk("t4_ovld_hold", out_valid_0, 1'b1);
    end
    wait_done();

    // Async reset mid-job, then a fresh job 2*2 = 4
    start_job(16'd8);
    feed(64'd1, 64'd1);
    feed(64'd2, 64'd2);
    feed(64'd3, 64'd3);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy_0, 1'b0);
    chk("t5_in_ready", in_ready_0, 1'b0);
    chk("t5_out_valid", out_valid_0, 1'b0);
    chk("t5_out_sum", out_sum_0, 136'd0);
    chk("t5_out_sum_1", out_sum_1, 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    push(136'd4, 1'b0, 136'd4, 1'b0);
    start_job(16'd1);
    feed(64'd2, 64'd2);
    wait_done();

    tick();
    tick();
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vedic_64_dot_acc.md
Name: vedic_64_dot_acc

Overview:
- Dot-product sequencer and accumulator that sits directly downstream of the 64x64 registered Vedic multiplier.
- Accepts a stream of 64-bit operand pairs and drives the multiplier's a/b inputs.
- Tracks the multiplier's pipeline latency, sums the 128-bit products into a wide accumulator, and returns one result per job through a valid/ready handshake.

Parameters:
- MUL_LAT, 2: cycles from mul_a/mul_b update to the matching mul_result being stable. Must be 1 or greater.
- ACC_W, 136: accumulator and out_sum width. Must be 128 or greater.
- LEN_W, 16: width of dot_len and of the internal issue/retire counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle job start; sampled only in IDLE
- dot_len  in  LEN_W  number of pairs in the job; latched on start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair
- in_a  in  64  operand A
- in_b  in  64  operand B
- mul_a  out  64  registered operand A to the multiplier
- mul_b  out  64  registered operand B to the multiplier
- mul_result  in  128  product from the multiplier
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_sum  out  ACC_W  accumulated dot product
- out_ovf  out  1  sticky accumulator overflow for the current job

Behaviour:
- Reset: all outputs, state, counters, accumulator and valid pipe are cleared to 0 immediately on rst rising, independent of clk. State goes to IDLE.
- Reset mid-job abandons the job. No partial result is presented.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1: latch len=dot_len, clear acc, issued, retired and out_ovf.
  - If dot_len==0, go to DONE with out_sum=0. Otherwise go to RUN.
- start outside IDLE is ignored.
- RUN:
  - in_ready = (issued != len).
  - Handshake (in_valid & in_ready) at edge E: mul_a<=in_a, mul_b<=in_b, issued++, and a 1 enters the head of a MUL_LAT-deep valid shift pipe.
  - No handshake: mul_a and mul_b hold their value and a 0 enters the pipe.
  - Throughput is one pair per cycle.
  - When issued reaches len, go to DRAIN. in_ready drops in the next cycle.
- Retire:
  - When the pipe tail is 1 at an edge: acc <= acc + zero-extended mul_result, retired++.
  - The product of a pair accepted at edge E is added at edge E+MUL_LAT+1.
  - The pipe keeps shifting in RUN and DRAIN.
- DRAIN:
  - in_ready=0.
  - When retired==len after an edge, go to DONE on the next edge.
  - Transition to DONE requires an empty pipe.
- DONE:
  - out_valid=1, out_sum=acc, out_ovf valid.
  - out_sum is held stable until out_valid & out_ready.
  - On that handshake, go to IDLE and drop out_valid in the next cycle.
  - out_ready while not in DONE has no effect.
- Width rules: addition is performed at ACC_W+1 bits. A carry out of bit ACC_W-1 sets out_ovf, which stays set until the next start.
- Simultaneous events:
  - The RUN→DRAIN transition and a retire on the same edge are both honoured.
  - The final retire and the DRAIN→DONE check: DONE is entered on the edge after the counters match, never the same edge.

Optional Feature:
- Macro: VEDIC_DOT_ACC_SAT_EN.
- Defined: on overflow, acc saturates to all-ones (2^ACC_W-1) and remains saturated for the rest of the job. out_ovf is set.
- Undefined: acc wraps modulo 2^ACC_W. out_ovf still flags the wrap.
- The port list is identical in both builds.

Test Plan:
- Single term, MUL_LAT=2, multiplier model attached: start with dot_len=1, pair accepted at edge E with in_a=3, in_b=5. Required: acc=15 at edge E+3, out_valid high after edge E+4, out_sum=15, out_ovf=0. out_ready=1 then returns busy=0.
- Back-to-back stream: dot_len=4 with pairs (1,2), (3,4), (5,6), (7,8) on consecutive cycles, in_valid held high. Required: in_ready low after the 4th accept, out_sum=100, no bubbles on mul_a.
- Max operands: dot_len=2, in_a=in_b=0xFFFF_FFFF_FFFF_FFFF. Required: out_sum=2^129-2^66+2 (ACC_W=136), out_ovf=0.
- Overflow with ACC_W=128 and the same stimulus as the max-operands test:
  - Macro undefined: out_sum=(2^129-2^66+2) mod 2^128, out_ovf=1.
  - Macro defined: out_sum=2^128-1, out_ovf=1.
- Zero-length job and backpressure: dot_len=0 gives out_valid with out_sum=0 on the cycle after start. Hold out_ready=0 for 5 cycles: out_sum stays stable, and a start pulse during DONE is ignored.
- Async reset mid-job: dot_len=8, assert rst between clock edges after 3 accepts. Required: busy, in_ready, out_valid and out_sum go to 0 immediately. A new job with dot_len=1, operands (2,2), then returns out_sum=4.
